inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Inverse of the core's immediate decode path. Accepts decoded instruction fields (format, opcode, register indices, funct fields, 32-bit immediate) over a valid/ready handshake.
- Range-checks the immediate and packs it into the RV32I bit layout for the given format.
- Writes each packed word into instruction memory at an auto-incrementing word address.
- Used by the bootloader/test infrastructure to assemble programs into IMEM without a host-side assembler.

Parameters:
- ADDR_W, 14, IMEM word-address width; the address wraps modulo 2^ADDR_W.
- CNT_W, 16, width of the instruction and error counters; counters saturate at all-ones.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; in IDLE, loads start_addr and enters RUN
- start_addr  in  ADDR_W  first IMEM word address
- stop  in  1  pulse; in RUN, enters DRAIN
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_fmt  in  3  0=R 1=I 2=I_SHAMT 3=S 4=B 5=U 6=J 7=CSRI
- in_opcode  in  7  placed at inst[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  placed at inst[14:12]
- in_funct7  in  7  placed at inst[31:25] (R, I_SHAMT)
- in_imm  in  32  immediate, sign-extended value
- imem_we  out  1  write request
- imem_ready  in  1  IMEM accepts the write this cycle
- imem_addr  out  ADDR_W  write word address
- imem_din  out  32  packed instruction
- busy  out  1  state != IDLE
- err_range  out  1  sticky; set by any dropped instruction, cleared by start or rst
- inst_count  out  CNT_W  words written since start
- err_count  out  CNT_W  instructions dropped since start

Behaviour:
- Reset values: state=IDLE; in_ready, imem_we, busy, err_range = 0; imem_addr, imem_din, inst_count, err_count = 0. Reset mid-operation discards any pending write.
- State machine:
  - IDLE: in_ready=0. start loads the address, clears the counters and err_range, then goes to RUN. stop is ignored.
  - RUN: in_ready = !imem_we || imem_ready. stop goes to DRAIN; start is ignored. If stop coincides with an accept, that bundle is still taken.
  - DRAIN: in_ready=0. Go to IDLE in the cycle where !imem_we, or when imem_we && imem_ready.
- Output stage is a 1-entry register.
  - A bundle accepted in cycle N drives imem_we=1 in cycle N+1.
  - imem_we, imem_addr and imem_din hold stable until imem_ready is sampled high.
  - Back-to-back throughput is 1 word/cycle while imem_ready stays high.
- A write completes when imem_we && imem_ready. On completion: imem_addr+1 (wraps from 2^ADDR_W-1 to 0) and inst_count+1.
- Range checks (fail means the bundle is dropped: no write, err_range=1, err_count+1, bundle still consumed):
  - I, S: imm must lie in [-2048, 2047].
  - I_SHAMT: imm must lie in [0, 31].
  - B: imm must lie in [-4096, 4094] and imm[0]=0.
  - J: imm must lie in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - CSRI: imm must lie in [0, 31].
  - R: imm is ignored.
- Packing (unlisted fields are 0):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0] to [31:20]; rs1, funct3, rd.
  - I_SHAMT: funct7 to [31:25], imm[4:0] to [24:20]; rs1, funct3, rd.
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7]; rs2, rs1, funct3.
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7]; rs2, rs1, funct3.
  - U: imm[31:12] to [31:12]; rd.
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12]; rd.
  - CSRI: {funct7, rs2} (12-bit CSR address) to [31:20], imm[4:0] to [19:15]; funct3, rd.
- The pack and range check are combinational on input fields; the result is registered into the output stage.

Decomposition:
- Shared package riscv_fmt_pkg holds:
  - the format codes (FMT_R..FMT_CSRI);
  - opcode constants 7'h03/13/17/23/37/63/67/6F/73;
  - immediate range limits.
- One combinational sub-module, imm_packer: inputs fmt, imm and the fields; outputs inst[31:0] and range_ok. It gets its own unit bench.
- The FSM, output register and counters live in the top module.

Test Plan:
- start_addr=0x10, I addi: opcode 0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> one cycle later imem_we=1, addr=0x10, din=0xFFF00093; inst_count=1.
- S sw: opcode 0x23, funct3=2, rs1=1, rs2=2, imm=4 -> din=0x0020A223. U lui: opcode 0x37, rd=5, imm=0x12345000 -> din=0x123452B7. J jal: opcode 0x6F, rd=1, imm=8 -> din=0x008000EF.
- B with imm=3, then I with imm=2048 -> no imem_we; err_range=1, err_count=2, imem_addr unchanged. A following valid bundle is written at the unchanged address.
- Hold imem_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after the first accept; din and addr stable. Release -> 1 word/cycle resumes with no loss or duplication.
- ADDR_W=4, start_addr=15, three writes -> addresses 15, 0, 1.
- stop asserted while a write is pending -> DRAIN, then IDLE after the write completes. rst asserted mid-RUN -> imem_we=0 immediately, all counters 0.

Source files
------------

// File: rtl/riscv_fmt_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fmt_pkg
// Shared definitions for the RV32I instruction encoder:
//   - fmt_e       : instruction format codes carried on in_fmt
//   - OPC_*       : base opcode constants used by program builders
//   - IMM*_MIN/MAX: signed immediate range limits per format
//   - imm_in_range: signed range helper used by the packer
// -----------------------------------------------------------------------------
package riscv_fmt_pkg;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_I_SHAMT = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_U       = 3'd5,
        FMT_J       = 3'd6,
        FMT_CSRI    = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;
    localparam int UIMM5_MIN = 0;
    localparam int UIMM5_MAX = 31;

    // Treats imm as a two's-complement value and tests lo <= imm <= hi.
    function automatic logic imm_in_range(input logic [31:0] imm,
                                          input int          lo,
                                          input int          hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/imm_packer.sv
// -----------------------------------------------------------------------------
// imm_packer
// Combinational RV32I packer: range-checks the immediate for the selected
// format and assembles the 32-bit instruction word. Fields not used by a
// format are left 0 in the word.
// Ports:
//   fmt_i      format code (fmt_e)
//   opcode_i   inst[6:0]
//   rd_i, rs1_i, rs2_i, funct3_i, funct7_i   register / function fields
//   imm_i      sign-extended immediate
//   inst_o     packed instruction
//   range_ok_o 1 when the immediate is encodable in the selected format
// -----------------------------------------------------------------------------
module imm_packer
    import riscv_fmt_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] inst_o,
    output logic        range_ok_o
);

    always_comb begin
        inst_o     = '0;
        range_ok_o = 1'b0;
        case (fmt_i)
            FMT_R: begin
                range_ok_o = 1'b1;
                inst_o     = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                range_ok_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
                inst_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I_SHAMT: begin
                range_ok_o = imm_in_range(imm_i, UIMM5_MIN, UIMM5_MAX);
                inst_o     = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_S: begin
                range_ok_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
                inst_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            FMT_B: begin
                range_ok_o = imm_in_range(imm_i, IMMB_MIN, IMMB_MAX) && !imm_i[0];
                inst_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
            end
            FMT_U: begin
                range_ok_o = (imm_i[11:0] == 12'd0);
                inst_o     = {imm_i[31:12], rd_i, opcode_i};
            end
            FMT_J: begin
                range_ok_o = imm_in_range(imm_i, IMMJ_MIN, IMMJ_MAX) && !imm_i[0];
                inst_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                              rd_i, opcode_i};
            end
            FMT_CSRI: begin
                // CSR address travels as {funct7, rs2}; the 5-bit uimm sits in the rs1 slot.
                range_ok_o = imm_in_range(imm_i, UIMM5_MIN, UIMM5_MAX);
                inst_o     = {funct7_i, rs2_i, imm_i[4:0], funct3_i, rd_i, opcode_i};
            end
            default: begin
                range_ok_o = 1'b0;
                inst_o     = '0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// -----------------------------------------------------------------------------
// inst_encoder_loader
// Accepts decoded instruction fields over valid/ready, packs them into RV32I
// words and writes them to IMEM at an auto-incrementing word address.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, start_addr   in IDLE: load first address, clear counters, enter RUN
//   stop                in RUN: enter DRAIN (finish pending write, then IDLE)
//   in_valid/in_ready   field bundle handshake
//   in_fmt .. in_imm    decoded instruction fields
//   imem_we/imem_ready  IMEM write handshake; imem_addr/imem_din held while pending
//   busy                state != IDLE
//   err_range           sticky: some bundle was dropped for an out-of-range immediate
//   inst_count          words written since start (saturating)
//   err_count           bundles dropped since start (saturating)
// -----------------------------------------------------------------------------
module inst_encoder_loader
    import riscv_fmt_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              busy,
    output logic              err_range,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [31:0]        pack_inst;
    logic               pack_ok;
    logic               accept;
    logic               write_done;

    imm_packer u_packer (
        .fmt_i      (fmt_e'(in_fmt)),
        .opcode_i   (in_opcode),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .funct3_i   (in_funct3),
        .funct7_i   (in_funct7),
        .imm_i      (in_imm),
        .inst_o     (pack_inst),
        .range_ok_o (pack_ok)
    );

    // The output register can take a new word in the same cycle it retires one.
    assign in_ready   = (state_q == ST_RUN) && (!we_q || imem_ready);
    assign accept     = in_valid && in_ready;
    assign write_done = we_q && imem_ready;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        err_d      = err_q;
        inst_cnt_d = inst_cnt_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = start_addr;
                    inst_cnt_d = '0;
                    err_cnt_d  = '0;
                    err_d      = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!we_q || imem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Retire first, then let a same-cycle accept refill the register.
        if (write_done) begin
            we_d   = 1'b0;
            addr_d = addr_q + 1'b1;
            if (inst_cnt_q != '1) begin
                inst_cnt_d = inst_cnt_q + 1'b1;
            end
        end

        if (accept) begin
            if (pack_ok) begin
                we_d  = 1'b1;
                din_d = pack_inst;
            end else begin
                err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            err_q      <= 1'b0;
            inst_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            err_q      <= err_d;
            inst_cnt_q <= inst_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_din   = din_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_range  = err_q;
    assign inst_count = inst_cnt_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
module tb_inst_encoder_loader;

    localparam int F_R = 0, F_I = 1, F_ISH = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6, F_CSRI = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, in_valid = 1'b0, imem_ready = 1'b0;
    logic [13:0] start_addr = '0;
    logic [2:0]  in_fmt = '0, in_funct3 = '0;
    logic [6:0]  in_opcode = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_ready, imem_we, busy, err_range;
    logic [13:0] imem_addr;
    logic [31:0] imem_din;
    logic [15:0] inst_count, err_count;

    // Small-address instance for wrap-around; shares field inputs and stop.
    logic        w_start = 1'b0, w_in_valid = 1'b0, w_imem_ready = 1'b0;
    logic [3:0]  w_start_addr = '0;
    logic        w_in_ready, w_imem_we, w_busy, w_err_range;
    logic [3:0]  w_imem_addr;
    logic [31:0] w_imem_din;
    logic [15:0] w_inst_count, w_err_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(14), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_din(imem_din), .busy(busy), .err_range(err_range),
        .inst_count(inst_count), .err_count(err_count)
    );

    inst_encoder_loader #(.ADDR_W(4), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .start_addr(w_start_addr), .stop(stop),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .imem_we(w_imem_we), .imem_ready(w_imem_ready),
        .imem_addr(w_imem_addr), .imem_din(w_imem_din), .busy(w_busy), .err_range(w_err_range),
        .inst_count(w_inst_count), .err_count(w_err_count)
    );

    // Reference encoder: range rules and field placement by shift/mask arithmetic.
    function automatic void model_encode(input int fmt, input bit [31:0] op, input bit [31:0] rd,
                                         input bit [31:0] rs1, input bit [31:0] rs2,
                                         input bit [31:0] f3, input bit [31:0] f7,
                                         input bit [31:0] imm, output bit ok, output bit [31:0] w);
        int v;
        v  = int'(imm);
        ok = 1'b1;
        w  = op & 32'h7F;
        case (fmt)
            F_R:   w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
            F_I: begin
                ok = (v >= -2048) && (v <= 2047);
                w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
            end
            F_ISH: begin
                ok = (v >= 0) && (v <= 31);
                w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (f7 << 25);
            end
            F_S: begin
                ok = (v >= -2048) && (v <= 2047);
                w |= ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                   | (((imm >> 5) & 127) << 25);
            end
            F_B: begin
                ok = (v >= -4096) && (v <= 4094) && (imm[0] == 1'b0);
                w |= (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12)
                   | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 63) << 25)
                   | (((imm >> 12) & 1) << 31);
            end
            F_U: begin
                ok = ((imm & 32'hFFF) == 0);
                w |= (rd << 7) | (imm & 32'hFFFFF000);
            end
            F_J: begin
                ok = (v >= -1048576) && (v <= 1048574) && (imm[0] == 1'b0);
                w |= (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                   | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
            end
            default: begin
                ok = (v >= 0) && (v <= 31);
                w |= (rd << 7) | (f3 << 12) | ((imm & 31) << 15) | (rs2 << 20) | (f7 << 25);
            end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input int fmt, input int op, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7, input logic [31:0] imm);
        in_fmt    = 3'(fmt);
        in_opcode = 7'(op);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = imm;
    endtask

    // Presents the current bundle until accepted (bounded); returns #1 after the accept edge.
    task automatic send_one(output bit acc);
        acc      = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    function automatic bit [31:0] enc_of(input int fmt, input int op, input int rd, input int rs1,
                                         input int rs2, input int f3, input int f7,
                                         input bit [31:0] imm);
        bit ok;
        bit [31:0] w;
        model_encode(fmt, op, rd, rs1, rs2, f3, f7, imm, ok, w);
        return w;
    endfunction

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick;
        total++;
        if ({in_ready, imem_we, busy, err_range, imem_addr, imem_din, inst_count, err_count} !== '0)
            $display("FAIL reset: got rdy=%b we=%b busy=%b err=%b addr=%h din=%h ic=%0d ec=%0d, want all 0",
                     in_ready, imem_we, busy, err_range, imem_addr, imem_din, inst_count, err_count);
        else passed++;
    endtask

    task automatic test_directed;
        bit acc;
        int          t_fmt[3] = '{F_S, F_U, F_J};
        int          t_op[3]  = '{'h23, 'h37, 'h6F};
        int          t_rd[3]  = '{0, 5, 1};
        int          t_rs1[3] = '{1, 0, 0};
        int          t_rs2[3] = '{2, 0, 0};
        int          t_f3[3]  = '{2, 0, 0};
        logic [31:0] t_imm[3] = '{32'd4, 32'h12345000, 32'd8};
        logic [31:0] t_exp[3] = '{32'h0020A223, 32'h123452B7, 32'h008000EF};
        imem_ready = 1'b0;
        start_addr = 14'h10;
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else passed++;

        set_bundle(F_I, 'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
        send_one(acc);
        total++;
        if ({acc, imem_we, imem_addr, imem_din} !== {1'b1, 1'b1, 14'h10, 32'hFFF00093})
            $display("FAIL addi: got acc=%b we=%b addr=%h din=%h want 1 1 0010 fff00093",
                     acc, imem_we, imem_addr, imem_din);
        else passed++;
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        total++;
        if ({imem_we, inst_count} !== {1'b0, 16'd1})
            $display("FAIL addi_done: got we=%b ic=%0d want 0 1", imem_we, inst_count);
        else passed++;

        for (int i = 0; i < 3; i++) begin
            set_bundle(t_fmt[i], t_op[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], 0, t_imm[i]);
            send_one(acc);
            total++;
            if ({acc, imem_we, imem_addr, imem_din} !== {1'b1, 1'b1, 14'(17 + i), t_exp[i]})
                $display("FAIL pack%0d: got acc=%b we=%b addr=%h din=%h want 1 1 %h %h",
                         i, acc, imem_we, imem_addr, imem_din, 14'(17 + i), t_exp[i]);
            else passed++;
            imem_ready = 1'b1;
            tick;
            imem_ready = 1'b0;
        end
        total++;
        if (inst_count !== 16'd4) $display("FAIL dir_count: got %0d want 4", inst_count); else passed++;
    endtask

    task automatic test_range_errors;
        bit acc1, acc2, acc3;
        imem_ready = 1'b1;
        set_bundle(F_B, 'h63, 0, 1, 2, 0, 0, 32'd3);
        send_one(acc1);
        set_bundle(F_I, 'h13, 1, 0, 0, 0, 0, 32'd2048);
        send_one(acc2);
        total++;
        if ({acc1, acc2, imem_we, err_range, err_count, imem_addr} !== {1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 14'h14})
            $display("FAIL drop: got acc=%b%b we=%b err=%b ec=%0d addr=%h want 11 0 1 2 0014",
                     acc1, acc2, imem_we, err_range, err_count, imem_addr);
        else passed++;
        set_bundle(F_I, 'h13, 2, 0, 0, 0, 0, 32'd5);
        send_one(acc3);
        total++;
        if ({acc3, imem_we, imem_addr, imem_din} !== {1'b1, 1'b1, 14'h14, enc_of(F_I, 'h13, 2, 0, 0, 0, 0, 5)})
            $display("FAIL after_drop: got acc=%b we=%b addr=%h din=%h want 1 1 0014 %h",
                     acc3, imem_we, imem_addr, imem_din, enc_of(F_I, 'h13, 2, 0, 0, 0, 0, 5));
        else passed++;
        tick;
        total++;
        if ({imem_we, inst_count} !== {1'b0, 16'd5})
            $display("FAIL after_drop_done: got we=%b ic=%0d want 0 5", imem_we, inst_count);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] w[4];
        logic [13:0] a0 = 14'h15;
        for (int k = 0; k < 4; k++) w[k] = enc_of(F_I, 'h13, 3, 0, 0, 0, 0, 32'(k + 1));
        imem_ready = 1'b0;
        set_bundle(F_I, 'h13, 3, 0, 0, 0, 0, 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL stall_first: got in_ready=%b want 1", in_ready); else passed++;
        @(posedge clk);
        #1;
        set_bundle(F_I, 'h13, 3, 0, 0, 0, 0, 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({in_ready, imem_we, imem_din, imem_addr} !== {1'b0, 1'b1, w[0], a0})
                $display("FAIL stall%0d: got rdy=%b we=%b din=%h addr=%h want 0 1 %h %h",
                         c, in_ready, imem_we, imem_din, imem_addr, w[0], a0);
            else passed++;
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({imem_we, imem_din, imem_addr} !== {1'b1, w[i], 14'(a0 + i)})
                $display("FAIL stream%0d: got we=%b din=%h addr=%h want 1 %h %h",
                         i, imem_we, imem_din, imem_addr, w[i], 14'(a0 + i));
            else passed++;
            @(posedge clk);
            #1;
            if (i + 2 < 4) set_bundle(F_I, 'h13, 3, 0, 0, 0, 0, 32'(i + 3));
            else in_valid = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({imem_we, inst_count, imem_addr} !== {1'b0, 16'd9, 14'(a0 + 4)})
            $display("FAIL stream_end: got we=%b ic=%0d addr=%h want 0 9 %h",
                     imem_we, inst_count, imem_addr, 14'(a0 + 4));
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stop_drain;
        bit acc;
        logic [31:0] w7 = enc_of(F_I, 'h13, 4, 0, 0, 0, 0, 7);
        imem_ready = 1'b0;
        set_bundle(F_I, 'h13, 4, 0, 0, 0, 0, 32'd7);
        send_one(acc);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        in_valid = 1'b1;
        tick;
        total++;
        if ({acc, busy, imem_we, imem_din, imem_addr} !== {1'b1, 1'b1, 1'b1, w7, 14'h19})
            $display("FAIL drain_hold: got acc=%b busy=%b we=%b din=%h addr=%h want 1 1 1 %h 0019",
                     acc, busy, imem_we, imem_din, imem_addr, w7);
        else passed++;
        imem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL drain_ready: got %b want 0", in_ready); else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({busy, imem_we, inst_count} !== {1'b0, 1'b0, 16'd10})
            $display("FAIL drain_idle: got busy=%b we=%b ic=%0d want 0 0 10", busy, imem_we, inst_count);
        else passed++;
        tick;
        in_valid = 1'b0;
        total++;
        if ({busy, imem_we} !== 2'b00) $display("FAIL idle_ignore: got busy=%b we=%b want 0 0", busy, imem_we);
        else passed++;

        start_addr = 14'h200;
        start = 1'b1;
        tick;
        start = 1'b0;
        total++;
        if ({inst_count, err_count, err_range, imem_addr} !== {16'd0, 16'd0, 1'b0, 14'h200})
            $display("FAIL restart: got ic=%0d ec=%0d err=%b addr=%h want 0 0 0 0200",
                     inst_count, err_count, err_range, imem_addr);
        else passed++;
        set_bundle(F_U, 'h37, 9, 0, 0, 0, 0, 32'hABCDE000);
        in_valid = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stop = 1'b0;
        total++;
        if ({acc, imem_we, busy, imem_din} !== {1'b1, 1'b1, 1'b1, enc_of(F_U, 'h37, 9, 0, 0, 0, 0, 32'hABCDE000)})
            $display("FAIL stop_accept: got rdy=%b we=%b busy=%b din=%h want 1 1 1 %h", acc, imem_we, busy,
                     imem_din, enc_of(F_U, 'h37, 9, 0, 0, 0, 0, 32'hABCDE000));
        else passed++;
        tick;
        total++;
        if ({busy, imem_we, inst_count} !== {1'b0, 1'b0, 16'd1})
            $display("FAIL stop_accept_done: got busy=%b we=%b ic=%0d want 0 0 1", busy, imem_we, inst_count);
        else passed++;
    endtask

    function automatic logic [31:0] pick_imm();
        int bl[19] = '{-2048, 2047, 2048, -2049, 0, 31, 32, -1, 4094, 4095, 4096, -4096, -4098,
                       1048574, 1048575, -1048576, -1048578, 'h12345000, 'h800};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'(bl[$urandom_range(0, 18)]);
            2: return 32'($urandom_range(0, 8191)) - 32'd4096;
            default: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] q[$];
        int          exp_words = 0;
        int          exp_err   = 0;
        logic [13:0] exp_addr;
        bit          ok;
        bit [31:0]   w;
        int          n = 400;
        start_addr = 14'($urandom);
        exp_addr   = start_addr;
        start = 1'b1;
        tick;
        start = 1'b0;
        fork
            begin
                for (int c = 0; c < n; c++) begin
                    in_valid   = ($urandom_range(0, 9) < 7);
                    imem_ready = ($urandom_range(0, 9) < 7);
                    set_bundle($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                               $urandom_range(0, 127), pick_imm());
                    tick;
                end
                in_valid   = 1'b0;
                imem_ready = 1'b1;
                repeat (12) tick;
            end
            begin
                repeat (n + 12) begin
                    @(negedge clk);
                    if (imem_we && imem_ready) begin
                        total++;
                        if (q.size() == 0) begin
                            $display("FAIL rand_extra_write: got write addr=%h din=%h want none", imem_addr, imem_din);
                        end else begin
                            w = q.pop_front();
                            if (imem_din !== w || imem_addr !== exp_addr)
                                $display("FAIL rand_write: got addr=%h din=%h want addr=%h din=%h",
                                         imem_addr, imem_din, exp_addr, w);
                            else passed++;
                        end
                        exp_addr++;
                        exp_words++;
                    end
                    if (in_valid && in_ready) begin
                        model_encode(int'(in_fmt), 32'(in_opcode), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                                     32'(in_funct3), 32'(in_funct7), in_imm, ok, w);
                        if (ok) q.push_back(w);
                        else exp_err++;
                    end
                end
            end
        join
        total++;
        if (q.size() != 0) $display("FAIL rand_lost: got %0d words unwritten want 0", q.size()); else passed++;
        total++;
        if ({inst_count, err_count, err_range, imem_addr} !== {16'(exp_words), 16'(exp_err), exp_err != 0, exp_addr})
            $display("FAIL rand_counts: got ic=%0d ec=%0d err=%b addr=%h want %0d %0d %b %h",
                     inst_count, err_count, err_range, imem_addr, exp_words, exp_err, exp_err != 0, exp_addr);
        else passed++;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0) $display("FAIL rand_stop: got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_wrap;
        logic [3:0] exp_a[3] = '{4'd15, 4'd0, 4'd1};
        int sent = 0;
        int got  = 0;
        w_start_addr = 4'd15;
        w_start = 1'b1;
        tick;
        w_start = 1'b0;
        w_imem_ready = 1'b1;
        set_bundle(F_U, 'h37, 0, 0, 0, 0, 0, 32'h1000);
        w_in_valid = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (w_imem_we && w_imem_ready) begin
                total++;
                if (got >= 3) begin
                    $display("FAIL wrap_extra: got addr=%h want no write", w_imem_addr);
                end else if ({w_imem_addr, w_imem_din} !==
                             {exp_a[got], enc_of(F_U, 'h37, got, 0, 0, 0, 0, 32'((got + 1) << 12))})
                    $display("FAIL wrap%0d: got addr=%h din=%h want %h %h", got, w_imem_addr, w_imem_din,
                             exp_a[got], enc_of(F_U, 'h37, got, 0, 0, 0, 0, 32'((got + 1) << 12)));
                else passed++;
                got++;
            end
            if (w_in_valid && w_in_ready) sent++;
            @(posedge clk);
            #1;
            if (sent >= 3) w_in_valid = 1'b0;
            else set_bundle(F_U, 'h37, sent, 0, 0, 0, 0, 32'((sent + 1) << 12));
        end
        w_in_valid = 1'b0;
        total++;
        if ({got, w_inst_count, w_imem_addr} !== {32'd3, 16'd3, 4'd2})
            $display("FAIL wrap_end: got n=%0d ic=%0d addr=%h want 3 3 2", got, w_inst_count, w_imem_addr);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit acc1, acc2;
        start_addr = 14'h33;
        start = 1'b1;
        tick;
        start = 1'b0;
        imem_ready = 1'b1;
        set_bundle(F_I, 'h13, 6, 1, 0, 0, 0, 32'd100);
        send_one(acc1);
        tick;
        imem_ready = 1'b0;
        set_bundle(F_I, 'h13, 6, 1, 0, 0, 0, 32'd101);
        send_one(acc2);
        total++;
        if ({acc1, acc2, imem_we, inst_count, busy} !== {1'b1, 1'b1, 1'b1, 16'd1, 1'b1})
            $display("FAIL pre_rst: got acc=%b%b we=%b ic=%0d busy=%b want 11 1 1 1",
                     acc1, acc2, imem_we, inst_count, busy);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({imem_we, busy, in_ready, err_range, inst_count, err_count, imem_addr, imem_din} !== '0)
            $display("FAIL mid_rst: got we=%b busy=%b rdy=%b err=%b ic=%0d ec=%0d addr=%h din=%h want all 0",
                     imem_we, busy, in_ready, err_range, inst_count, err_count, imem_addr, imem_din);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        tick;
        total++;
        if ({imem_we, busy} !== 2'b00) $display("FAIL post_rst: got we=%b busy=%b want 0 0", imem_we, busy);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_range_errors;
        test_back_to_back;
        test_stop_drain;
        test_random;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
